// File: rtl/overlay_rom_scheduler.sv
// Overlay ROM read scheduler: per-pixel icon/glyph ROM addresses, enables and a latency-aligned region tag.
// Optional blinking of the alarm icons is built when OVERLAY_BLINK_EN is defined.
module overlay_rom_scheduler #(
  parameter int unsigned ICON_W       = 120,
  parameter int unsigned FIRE_X0      = 521,
  parameter int unsigned WARN_X0      = 401,
  parameter int unsigned ICON_Y0      = 1,
  parameter int unsigned DIG_W        = 80,
  parameter int unsigned DIG_H        = 120,
  parameter int unsigned TENS_X0      = 321,
  parameter int unsigned ONES_X0      = 401,
  parameter int unsigned DIG_Y0       = 151,
  parameter int unsigned ROM_LAT      = 1,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_en,
  input  logic [10:0] i_x,
  input  logic [9:0]  i_y,
  input  logic        i_is_fire,
  input  logic        i_is_warning,
  input  logic [3:0]  i_tens,
  input  logic [3:0]  i_ones,
  output logic [13:0] o_icon_addr,
  output logic        o_fire_en,
  output logic        o_warn_en,
  output logic [16:0] o_glyph_addr,
  output logic        o_glyph_en,
  output logic [2:0]  o_region
);

  localparam logic [2:0] REG_NONE  = 3'd0;
  localparam logic [2:0] REG_FIRE  = 3'd1;
  localparam logic [2:0] REG_WARN  = 3'd2;
  localparam logic [2:0] REG_TENS  = 3'd3;
  localparam logic [2:0] REG_ONES  = 3'd4;
  localparam logic [2:0] REG_BLANK = 3'd5;
  localparam logic [3:0] DIG_MAX   = 4'd9;

  typedef enum logic [0:0] {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        fire_q, warn_q;
  logic [3:0]  tens_q, ones_q;
  logic [13:0] icon_addr_q, icon_addr_d;
  logic        fire_en_q, fire_en_d;
  logic        warn_en_q, warn_en_d;
  logic [16:0] glyph_addr_q, glyph_addr_d;
  logic        glyph_en_q, glyph_en_d;
  logic [2:0]  tag1_q, tag1_d;
  logic [2:0]  tag_pipe_q [ROM_LAT];

  logic        frame_start_s, blink_s, fire_vis_s, warn_vis_s;
  logic        in_fire_s, in_warn_s, in_tens_s, in_ones_s;
  logic [31:0] x_s, y_s;
  logic [13:0] fire_addr_s, warn_addr_s;
  logic [16:0] tens_addr_s, ones_addr_s;

  assign frame_start_s = i_pix_en && (i_x == 11'd0) && (i_y == 10'd0);
  assign x_s = {21'd0, i_x};
  assign y_s = {22'd0, i_y};

  // Products are formed at 32 bits and only the final sum is narrowed to the ROM address width.
  assign fire_addr_s = 14'((y_s - ICON_Y0) * ICON_W + (x_s - FIRE_X0));
  assign warn_addr_s = 14'((y_s - ICON_Y0) * ICON_W + (x_s - WARN_X0));
  assign tens_addr_s = 17'(32'(tens_q) * DIG_W * DIG_H + (y_s - DIG_Y0) * DIG_W + (x_s - TENS_X0));
  assign ones_addr_s = 17'(32'(ones_q) * DIG_W * DIG_H + (y_s - DIG_Y0) * DIG_W + (x_s - ONES_X0));

  assign in_fire_s = (x_s >= FIRE_X0) && (x_s <= FIRE_X0 + ICON_W - 1) &&
                     (y_s >= ICON_Y0) && (y_s <= ICON_Y0 + ICON_W - 1);
  assign in_warn_s = (x_s >= WARN_X0) && (x_s <= WARN_X0 + ICON_W - 1) &&
                     (y_s >= ICON_Y0) && (y_s <= ICON_Y0 + ICON_W - 1);
  assign in_tens_s = (x_s >= TENS_X0) && (x_s <= TENS_X0 + DIG_W - 1) &&
                     (y_s >= DIG_Y0) && (y_s <= DIG_Y0 + DIG_H - 1);
  assign in_ones_s = (x_s >= ONES_X0) && (x_s <= ONES_X0 + DIG_W - 1) &&
                     (y_s >= DIG_Y0) && (y_s <= DIG_Y0 + DIG_H - 1);

`ifdef OVERLAY_BLINK_EN
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  // Blink counter advances once per frame only while an alarm persists, so a new alarm shows at once.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start_s) begin
      if (!(i_is_fire || i_is_warning)) begin
        blink_cnt_d   = {CNT_W{1'b0}};
        blink_phase_d = 1'b0;
      end else if (fire_q || warn_q) begin
        if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d   = {CNT_W{1'b0}};
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
      end else begin
        blink_cnt_d   = {CNT_W{1'b0}};
        blink_phase_d = 1'b0;
      end
    end else begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
    end
  end

  // Blink state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_q   <= {CNT_W{1'b0}};
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_s = blink_phase_q;
`else
  assign blink_s = 1'b0;
`endif

  assign fire_vis_s = fire_q && !blink_s;
  assign warn_vis_s = warn_q && !blink_s;

  // FSM next state: wait for the first frame start, then run until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC: begin
        if (frame_start_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_SYNC;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_SYNC;
    endcase
  end

  // Stage-1 region decode in priority order; addresses hold while their enable is low.
  always_comb begin
    icon_addr_d  = icon_addr_q;
    fire_en_d    = fire_en_q;
    warn_en_d    = warn_en_q;
    glyph_addr_d = glyph_addr_q;
    glyph_en_d   = glyph_en_q;
    tag1_d       = tag1_q;
    if (i_pix_en && (state_q == S_RUN)) begin
      fire_en_d  = 1'b0;
      warn_en_d  = 1'b0;
      glyph_en_d = 1'b0;
      if (in_fire_s && fire_vis_s) begin
        fire_en_d   = 1'b1;
        icon_addr_d = fire_addr_s;
        tag1_d      = REG_FIRE;
      end else if (in_warn_s && warn_vis_s) begin
        warn_en_d   = 1'b1;
        icon_addr_d = warn_addr_s;
        tag1_d      = REG_WARN;
      end else if (in_tens_s) begin
        if (tens_q <= DIG_MAX) begin
          glyph_en_d   = 1'b1;
          glyph_addr_d = tens_addr_s;
          tag1_d       = REG_TENS;
        end else begin
          tag1_d = REG_BLANK;
        end
      end else if (in_ones_s) begin
        if (ones_q <= DIG_MAX) begin
          glyph_en_d   = 1'b1;
          glyph_addr_d = ones_addr_s;
          tag1_d       = REG_ONES;
        end else begin
          tag1_d = REG_BLANK;
        end
      end else begin
        tag1_d = REG_NONE;
      end
    end else begin
      tag1_d = tag1_q;
    end
  end

  // State, frame latch and stage-1 registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_SYNC;
      fire_q       <= 1'b0;
      warn_q       <= 1'b0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      icon_addr_q  <= 14'd0;
      fire_en_q    <= 1'b0;
      warn_en_q    <= 1'b0;
      glyph_addr_q <= 17'd0;
      glyph_en_q   <= 1'b0;
      tag1_q       <= REG_NONE;
    end else if (i_pix_en) begin
      state_q      <= state_d;
      icon_addr_q  <= icon_addr_d;
      fire_en_q    <= fire_en_d;
      warn_en_q    <= warn_en_d;
      glyph_addr_q <= glyph_addr_d;
      glyph_en_q   <= glyph_en_d;
      tag1_q       <= tag1_d;
      if (frame_start_s) begin
        fire_q <= i_is_fire;
        warn_q <= i_is_warning;
        tens_q <= i_tens;
        ones_q <= i_ones;
      end else begin
        fire_q <= fire_q;
        warn_q <= warn_q;
        tens_q <= tens_q;
        ones_q <= ones_q;
      end
    end else begin
      state_q <= state_q;
    end
  end

  // Tag delay line so o_region matches the ROM data currently on douta.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(ROM_LAT); i++) begin
        tag_pipe_q[i] <= REG_NONE;
      end
    end else if (i_pix_en) begin
      tag_pipe_q[0] <= tag1_q;
      for (int i = int'(ROM_LAT) - 1; i > 0; i--) begin
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end else begin
      tag_pipe_q[0] <= tag_pipe_q[0];
    end
  end

  assign o_icon_addr  = icon_addr_q;
  assign o_fire_en    = fire_en_q;
  assign o_warn_en    = warn_en_q;
  assign o_glyph_addr = glyph_addr_q;
  assign o_glyph_en   = glyph_en_q;
  assign o_region     = tag_pipe_q[ROM_LAT-1];

endmodule

// File: tb/tb_overlay_rom_scheduler.sv
// Self-checking bench for overlay_rom_scheduler: directed table, corner sequences and a randomized run
// against a rectangle-based reference model.
module tb_overlay_rom_scheduler;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [10:0] x_in = 11'd0;
  logic [9:0]  y_in = 10'd0;
  logic        is_fire = 1'b0, is_warn = 1'b0;
  logic [3:0]  tens = 4'd0, ones = 4'd0;
  logic [13:0] icon_addr;
  logic        fire_en, warn_en, glyph_en;
  logic [16:0] glyph_addr;
  logic [2:0]  region;

  int checks = 0;
  int failures = 0;

  overlay_rom_scheduler #(.ROM_LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_x(x_in), .i_y(y_in),
    .i_is_fire(is_fire), .i_is_warning(is_warn), .i_tens(tens), .i_ones(ones),
    .o_icon_addr(icon_addr), .o_fire_en(fire_en), .o_warn_en(warn_en),
    .o_glyph_addr(glyph_addr), .o_glyph_en(glyph_en), .o_region(region)
  );

  always #5 clk = ~clk;

  // Reference model: screen rectangles and the address formulas, evaluated per strobe.
  bit m_run, m_f, m_w;
  int m_t, m_o;
  int m_fe, m_we, m_ge, m_ia, m_ga, m_reg;
  int m_tags[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit inside_rect(int x, int y, int x0, int y0, int w, int h);
    return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
  endfunction

  task automatic model_reset();
    m_run = 0; m_f = 0; m_w = 0; m_t = 0; m_o = 0;
    m_fe = 0; m_we = 0; m_ge = 0; m_ia = 0; m_ga = 0; m_reg = 0;
    m_tags = {};
    for (int i = 0; i <= LAT; i++) m_tags.push_back(0);
  endtask

  task automatic model_strobe(input int x, input int y);
    int t;
    t = m_tags[0];
    if (m_run) begin
      m_fe = 0; m_we = 0; m_ge = 0; t = 0;
      if (m_f && inside_rect(x, y, 521, 1, 120, 120)) begin
        m_fe = 1; m_ia = (y - 1) * 120 + (x - 521); t = 1;
      end else if (m_w && inside_rect(x, y, 401, 1, 120, 120)) begin
        m_we = 1; m_ia = (y - 1) * 120 + (x - 401); t = 2;
      end else if (inside_rect(x, y, 321, 151, 80, 120)) begin
        if (m_t < 10) begin m_ge = 1; m_ga = m_t * 9600 + (y - 151) * 80 + (x - 321); t = 3; end
        else t = 5;
      end else if (inside_rect(x, y, 401, 151, 80, 120)) begin
        if (m_o < 10) begin m_ge = 1; m_ga = m_o * 9600 + (y - 151) * 80 + (x - 401); t = 4; end
        else t = 5;
      end
    end
    m_tags.push_front(t);
    void'(m_tags.pop_back());
    m_reg = m_tags[LAT];
    if (x == 0 && y == 0) begin
      m_run = 1; m_f = is_fire; m_w = is_warn; m_t = int'(tens); m_o = int'(ones);
    end
  endtask

  task automatic step(input bit en, input int x, input int y);
    pix_en = en; x_in = 11'(x); y_in = 10'(y);
    @(posedge clk);
    if (en) model_strobe(x, y);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_fire_en"}, {31'd0, fire_en}, 32'(m_fe));
    chk({tag, "_warn_en"}, {31'd0, warn_en}, 32'(m_we));
    chk({tag, "_glyph_en"}, {31'd0, glyph_en}, 32'(m_ge));
    chk({tag, "_icon_addr"}, {18'd0, icon_addr}, 32'(m_ia));
    chk({tag, "_glyph_addr"}, {15'd0, glyph_addr}, 32'(m_ga));
    chk({tag, "_region"}, {29'd0, region}, 32'(m_reg));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fire_en"}, {31'd0, fire_en}, 32'd0);
    chk({tag, "_warn_en"}, {31'd0, warn_en}, 32'd0);
    chk({tag, "_glyph_en"}, {31'd0, glyph_en}, 32'd0);
    chk({tag, "_icon_addr"}, {18'd0, icon_addr}, 32'd0);
    chk({tag, "_glyph_addr"}, {15'd0, glyph_addr}, 32'd0);
    chk({tag, "_region"}, {29'd0, region}, 32'd0);
  endtask

  typedef struct {
    bit fire; bit warn; int tens; int ones; int x; int y;
    int fe; int we; int ia; int ge; int ga; int tag;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1, 0, 0, 0,  521,   1, 1, 0,     0, 0,     0, 1};
    vecs[1]  = '{1, 0, 0, 0,  640, 120, 1, 0, 14399, 0,     0, 1};
    vecs[2]  = '{1, 0, 0, 0,  641, 120, 0, 0,     0, 0,     0, 0};
    vecs[3]  = '{0, 1, 0, 0,  401,   1, 0, 1,     0, 0,     0, 2};
    vecs[4]  = '{1, 1, 0, 0,  520, 120, 0, 1, 14399, 0,     0, 2};
    vecs[5]  = '{0, 1, 0, 0,  600,  50, 0, 0,     0, 0,     0, 0};
    vecs[6]  = '{0, 0, 4, 0,  330, 160, 0, 0,     0, 1, 39129, 3};
    vecs[7]  = '{0, 0, 0, 9,  401, 151, 0, 0,     0, 1, 86400, 4};
    vecs[8]  = '{0, 0, 0, 12, 420, 200, 0, 0,     0, 0,     0, 5};
    vecs[9]  = '{0, 0, 10, 0, 321, 151, 0, 0,     0, 0,     0, 5};
    vecs[10] = '{0, 0, 9, 0,  400, 270, 0, 0,     0, 1, 95999, 3};
    vecs[11] = '{0, 0, 0, 0,  320, 151, 0, 0,     0, 0,     0, 0};
    vecs[12] = '{0, 1, 2, 5,  480, 270, 0, 0,     0, 1, 57599, 4};

    model_reset();
    #12;
    chk_zero("reset");
    rst_n = 1'b1;

    // Outputs stay quiet before the first frame start even with fire asserted.
    is_fire = 1'b1;
    step(1, 521, 1);
    chk("sync_fire_en", {31'd0, fire_en}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      is_fire = vecs[i].fire; is_warn = vecs[i].warn;
      tens = 4'(vecs[i].tens); ones = 4'(vecs[i].ones);
      step(1, 0, 0);
      step(1, vecs[i].x, vecs[i].y);
      chk($sformatf("vec%0d_fire_en", i), {31'd0, fire_en}, 32'(vecs[i].fe));
      chk($sformatf("vec%0d_warn_en", i), {31'd0, warn_en}, 32'(vecs[i].we));
      chk($sformatf("vec%0d_glyph_en", i), {31'd0, glyph_en}, 32'(vecs[i].ge));
      if (vecs[i].fe == 1 || vecs[i].we == 1)
        chk($sformatf("vec%0d_icon_addr", i), {18'd0, icon_addr}, 32'(vecs[i].ia));
      if (vecs[i].ge == 1)
        chk($sformatf("vec%0d_glyph_addr", i), {15'd0, glyph_addr}, 32'(vecs[i].ga));
      step(1, 1000, 500);
      chk($sformatf("vec%0d_region", i), {29'd0, region}, 32'(vecs[i].tag));
    end

    // Digit change mid-frame is ignored until the next frame start.
    is_fire = 1'b0; is_warn = 1'b0; tens = 4'd1; ones = 4'd0;
    step(1, 0, 0);
    step(1, 330, 160);
    chk("tear_before", {15'd0, glyph_addr}, 32'd10329);
    tens = 4'd9;
    step(1, 330, 200);
    chk("tear_midframe", {15'd0, glyph_addr}, 32'd13529);
    step(1, 0, 0);
    step(1, 330, 200);
    chk("tear_nextframe", {15'd0, glyph_addr}, 32'd90329);

    // Strobe low: everything holds, including a frame-start coordinate.
    ones = 4'd9;
    step(1, 0, 0);
    step(1, 401, 151);
    for (int i = 0; i < 5; i++) begin
      is_fire = ~is_fire; tens = 4'($urandom_range(0, 15));
      step(0, (i == 0) ? 0 : 521, (i == 0) ? 0 : 1);
      chk("hold_glyph_en", {31'd0, glyph_en}, 32'd1);
      chk("hold_glyph_addr", {15'd0, glyph_addr}, 32'd86400);
      cmp_model("hold");
    end
    step(1, 1000, 500);
    chk("hold_region_after", {29'd0, region}, 32'd4);

    // Reset in mid-frame clears outputs immediately and waits for the next frame start.
    is_fire = 1'b1;
    step(1, 0, 0);
    step(1, 521, 1);
    chk("pre_reset_fire_en", {31'd0, fire_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    #2 rst_n = 1'b1;
    step(1, 530, 10);
    chk("post_reset_sync_fire_en", {31'd0, fire_en}, 32'd0);
    step(1, 1000, 500);
    chk("post_reset_sync_region", {29'd0, region}, 32'd0);
    step(1, 0, 0);
    step(1, 521, 1);
    chk("post_reset_fire_en", {31'd0, fire_en}, 32'd1);
    chk("post_reset_icon_addr", {18'd0, icon_addr}, 32'd0);
    step(1, 1000, 500);
    chk("post_reset_region", {29'd0, region}, 32'd1);

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      int rx, ry;
      if ($urandom_range(0, 9) == 0) is_fire = 1'($urandom);
      if ($urandom_range(0, 9) == 0) is_warn = 1'($urandom);
      if ($urandom_range(0, 4) == 0) tens = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) ones = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        rx = 0; ry = 0;
      end else begin
        rx = $urandom_range(300, 660); ry = $urandom_range(0, 290);
      end
      step(($urandom_range(0, 3) != 0), rx, ry);
      cmp_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
